video_timing_clamp: RTL and testbench
=====================================

Name: video_timing_clamp

Overview:
- Downstream of the sync detector. Consumes its `hsync`, `vsync`, `porch` and `blacklevel` outputs together with the raw 6-bit `cvbs` sample stream.
- Produces a black-clamped, gained luma sample, pixel and line coordinates, an active-video enable, field parity and a field-lock status.
- Feeds the line buffer / scan converter stage.

Parameters:
- CLK, 24e6, sample clock rate in Hz; documentation only.
- H_START, 160, first active pixel, counted in ce ticks after the hsync falling edge.
- H_ACTIVE, 1248, number of active pixels per line.
- V_START, 23, first active line after field start.
- V_ACTIVE, 288, number of active lines per field.
- HALFLINE, 768, x threshold used to classify field parity.
- VS_HOLD, 8, lines after field start during which further vsync edges are ignored.
- LINES_MIN, 310, lowest line count accepted as a valid field.
- LINES_MAX, 315, highest line count accepted as a valid field.
- GAIN_SHL, 1, left shift applied to clamped luma, with saturation.

Ports:
- clk  in  1  sample clock
- reset  in  1  synchronous, active-high reset
- ce  in  1  sample enable; all state advances only when ce=1
- cvbs  in  6  raw composite sample
- hsync  in  1  active-low horizontal sync from detector
- vsync  in  1  active-low vertical sync; toggles during equalising pulses
- porch  in  1  high during back porch
- blacklevel  in  6  measured black level
- luma  out  6  clamped and gained sample
- de  out  1  active-video enable, aligned with luma
- x  out  11  pixel counter
- y  out  9  line counter within field
- field  out  1  0 = first field, 1 = second field
- locked  out  1  field timing stable
- line_timeout  out  1  one-ce pulse when x saturates

Behaviour:
- Clock and reset:
  - Single clock `clk`; reset is synchronous and active-high.
  - While reset=1, all outputs and internal state are 0 on the next clk edge, regardless of ce.
- Input edge registers:
  - `hsync` and `vsync` are registered on ce to form previous-value registers.
  - hfall = prev_h & ~hsync.
  - vfall = prev_v & ~vsync.
  - Previous-value registers reset to 1.
- Horizontal counter:
  - On hfall, x_int <= 0. Otherwise x_int increments per ce, saturating at 2047.
  - line_timeout pulses for exactly one ce when x_int steps 2046 -> 2047; no pulse while held at 2047.
- Vertical counter:
  - On hfall, y_int increments, saturating at 511.
- Field start:
  - Occurs on vfall when hold_cnt == 0.
  - Actions on field start:
    - lines_last <= y_int
    - y_int <= 0
    - hold_cnt <= VS_HOLD
    - field_int <= (x_int >= HALFLINE)
  - hold_cnt decrements on each hfall while nonzero.
  - vfall with hold_cnt != 0 is ignored, which absorbs equalising/serration toggles.
- Simultaneous events:
  - hfall and field start in the same ce: y_int <= 0 wins.
  - x_int is still reset by hfall.
- Lock:
  - A field is good when LINES_MIN <= lines_last <= LINES_MAX, evaluated at field start.
  - A 2-bit counter good_cnt increments on good fields, saturating at 2; a bad field clears it.
  - locked = (good_cnt == 2).
  - line_timeout also clears good_cnt.
- Clamp datapath (1 ce latency):
  - d = cvbs - blacklevel if cvbs > blacklevel, else 0.
  - luma <= min(d << GAIN_SHL, 63), computed in 7+GAIN_SHL bits before saturation.
  - luma is forced to 0 while porch=1 or hsync=0.
- Output timing:
  - x, y and field are registered copies of x_int, y_int and field_int, aligned with luma (same ce).
  - de <= (H_START <= x_int < H_START+H_ACTIVE) & (V_START <= y_int < V_START+V_ACTIVE) & hsync & vsync & locked.
  - de and luma change only on ce.
- ce = 0: every register holds its value.

Decomposition:
- Package `video_timing_pkg`:
  - localparams for widths: PIX_W=6, X_W=11, Y_W=9.
  - PAL defaults: H_START, H_ACTIVE, V_START, V_ACTIVE, HALFLINE, LINES_MIN, LINES_MAX.
  - X_MAX=2047 and Y_MAX=511.
- One sub-module `luma_clamp`:
  - Inputs: clk, reset, ce, cvbs, blacklevel, blank.
  - Output: luma.
  - Parameter: GAIN_SHL.
  - Contains the saturating subtract/shift register.
  - Counters, lock logic and field logic stay in the top level.

Test Plan:
- Clamp: blacklevel=12, GAIN_SHL=1, hsync=vsync=1, porch=0; cvbs 10/12/20/50 -> luma 0/0/16/63 one ce later.
- Line timing: hsync low pulses every 1536 ce -> x runs 0..1535 and resets; y increments by 1 per line; de high exactly for x in 160..1407 once y in 23..310 and locked=1.
- Lock: 312 lines between field starts, with vfall at x=10 and then at x=778 on alternate fields -> lines_last=312, field alternates 0/1, locked=1 after the 2nd good field start; then one 300-line field -> locked=0 at that field start.
- Equalising: 10 vsync toggles within the first 4 lines after a field start -> exactly one field start, y counts continuously, hold_cnt prevents resets.
- Timeout: hsync held high for 3000 ce -> x saturates at 2047, line_timeout pulses exactly once, locked drops to 0, de=0.
- Reset mid-line: assert reset for 1 cycle at x=500, locked=1 -> next cycle all outputs 0, locked=0; the counter restarts from the following hsync.

Source files
------------

// File: rtl/video_timing_pkg.sv
// Shared widths, PAL default timing and a small window helper for the
// video timing / black-clamp stage that sits between the sync detector and
// the line buffer.
package video_timing_pkg;

   // Datapath and counter widths.
   localparam int unsigned PIX_W = 6;
   localparam int unsigned X_W   = 11;
   localparam int unsigned Y_W   = 9;

   // PAL timing defaults at a 24 MHz sample clock.
   localparam int unsigned PAL_H_START   = 160;
   localparam int unsigned PAL_H_ACTIVE  = 1248;
   localparam int unsigned PAL_V_START   = 23;
   localparam int unsigned PAL_V_ACTIVE  = 288;
   localparam int unsigned PAL_HALFLINE  = 768;
   localparam int unsigned PAL_LINES_MIN = 310;
   localparam int unsigned PAL_LINES_MAX = 315;

   // Counter saturation points.
   localparam logic [X_W-1:0] X_MAX = '1;
   localparam logic [Y_W-1:0] Y_MAX = '1;

   // True when start <= v < start + len.
   function automatic logic in_window(input int unsigned v,
                                      input int unsigned start,
                                      input int unsigned len);
      return (v >= start) && (v < start + len);
   endfunction

endpackage

// File: rtl/video_timing_clamp_luma_clamp.sv
// luma_clamp: registered black-level clamp with saturating gain.
//   clk, reset, ce  - sample clock, sync active-high reset, sample enable
//   cvbs            - raw composite sample
//   blacklevel      - measured black level subtracted from cvbs
//   blank           - forces the output to zero (porch / sync tip)
//   luma            - max(cvbs - blacklevel, 0) << GAIN_SHL, saturated to
//                     the pixel range, one ce after the inputs
module luma_clamp
   import video_timing_pkg::*;
#(
   parameter int unsigned GAIN_SHL = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ce,
   input  logic [PIX_W-1:0] cvbs,
   input  logic [PIX_W-1:0] blacklevel,
   input  logic             blank,
   output logic [PIX_W-1:0] luma
);

   localparam int unsigned WIDE_W = PIX_W + 1 + GAIN_SHL;

   logic [PIX_W-1:0] luma_q;
   logic [PIX_W-1:0] luma_d;

   // Signed difference so "below black" is a plain sign test; the shift is
   // done in a widened word and anything above the pixel range saturates.
   function automatic logic [PIX_W-1:0] clamp_gain(input logic [PIX_W-1:0] s,
                                                   input logic [PIX_W-1:0] b);
      logic signed [PIX_W+1:0] diff;
      logic        [WIDE_W-1:0] wide;
      diff = $signed({2'b00, s}) - $signed({2'b00, b});
      wide = '0;
      if (diff > $signed({(PIX_W+2){1'b0}})) begin
         wide = {{(GAIN_SHL+1){1'b0}}, diff[PIX_W-1:0]} << GAIN_SHL;
      end
      if (|wide[WIDE_W-1:PIX_W]) begin
         return '1;
      end
      return wide[PIX_W-1:0];
   endfunction

   always_comb begin
      luma_d = blank ? '0 : clamp_gain(cvbs, blacklevel);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         luma_q <= '0;
      end else if (ce) begin
         luma_q <= luma_d;
      end
   end

   assign luma = luma_q;

endmodule

// File: rtl/video_timing_clamp.sv
// video_timing_clamp: line/field timing recovery and black clamp.
// Takes the sync detector outputs plus the raw composite stream and feeds
// the line buffer / scan converter.
//   clk, reset, ce  - sample clock, sync active-high reset, sample enable
//   cvbs            - raw composite sample
//   hsync, vsync    - active-low syncs (vsync toggles during equalising)
//   porch           - high during back porch (luma blanked)
//   blacklevel      - measured black level
//   luma            - clamped, gained sample
//   de              - active-video enable, aligned with luma
//   x, y            - pixel and line counters, aligned with luma
//   field           - 0 first field, 1 second field
//   locked          - two consecutive fields of plausible length seen
//   line_timeout    - one-ce pulse when the pixel counter saturates
module video_timing_clamp
   import video_timing_pkg::*;
#(
   parameter int unsigned CLK       = 24000000,  // documentation only
   parameter int unsigned H_START   = PAL_H_START,
   parameter int unsigned H_ACTIVE  = PAL_H_ACTIVE,
   parameter int unsigned V_START   = PAL_V_START,
   parameter int unsigned V_ACTIVE  = PAL_V_ACTIVE,
   parameter int unsigned HALFLINE  = PAL_HALFLINE,
   parameter int unsigned VS_HOLD   = 8,
   parameter int unsigned LINES_MIN = PAL_LINES_MIN,
   parameter int unsigned LINES_MAX = PAL_LINES_MAX,
   parameter int unsigned GAIN_SHL  = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ce,
   input  logic [PIX_W-1:0] cvbs,
   input  logic             hsync,
   input  logic             vsync,
   input  logic             porch,
   input  logic [PIX_W-1:0] blacklevel,
   output logic [PIX_W-1:0] luma,
   output logic             de,
   output logic [X_W-1:0]   x,
   output logic [Y_W-1:0]   y,
   output logic             field,
   output logic             locked,
   output logic             line_timeout
);

   localparam int unsigned    HOLD_W   = $clog2(VS_HOLD + 1);
   localparam logic [X_W-1:0] HALF_X   = X_W'(HALFLINE);
   localparam logic [X_W-1:0] X_PRESAT = X_MAX - 1'b1;
   localparam logic [Y_W-1:0] LMIN_Y   = Y_W'(LINES_MIN);
   localparam logic [Y_W-1:0] LMAX_Y   = Y_W'(LINES_MAX);

   // Reject parameter sets the counters cannot represent.
   if (CLK == 0 || VS_HOLD == 0 || LINES_MIN > LINES_MAX ||
       LINES_MAX > 32'(Y_MAX) || H_START + H_ACTIVE > 32'(X_MAX)) begin : g_param_check
      $error("video_timing_clamp: invalid timing parameters");
   end

   logic              prev_h_q, prev_v_q;
   logic [X_W-1:0]    x_cnt_q, x_cnt_d;
   logic [Y_W-1:0]    y_cnt_q, y_cnt_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic              field_int_q, field_int_d;
   logic [Y_W-1:0]    lines_last_q, lines_last_d;
   logic [1:0]        good_q, good_d;
   logic              timeout_q, timeout_d;
   logic [X_W-1:0]    x_out_q;
   logic [Y_W-1:0]    y_out_q;
   logic              field_out_q;
   logic              de_q, de_d;

   logic hfall, vfall, field_start, good_field, locked_int;

   assign locked_int = (good_q == 2'd2);

   always_comb begin
      hfall       = prev_h_q & ~hsync;
      vfall       = prev_v_q & ~vsync;
      // vsync edges inside the hold window are equalising/serration pulses.
      field_start = vfall && (hold_q == '0);

      x_cnt_d      = x_cnt_q;
      y_cnt_d      = y_cnt_q;
      hold_d       = hold_q;
      field_int_d  = field_int_q;
      lines_last_d = lines_last_q;
      good_d       = good_q;
      timeout_d    = 1'b0;

      if (hfall) begin
         x_cnt_d = '0;
      end else if (x_cnt_q != X_MAX) begin
         x_cnt_d = x_cnt_q + 1'b1;
      end
      // Pulse only on the step into saturation, not while parked there.
      timeout_d = !hfall && (x_cnt_q == X_PRESAT);

      // A field start beats the line increment in the same ce.
      if (field_start) begin
         y_cnt_d = '0;
      end else if (hfall && (y_cnt_q != Y_MAX)) begin
         y_cnt_d = y_cnt_q + 1'b1;
      end

      if (field_start) begin
         hold_d = HOLD_W'(VS_HOLD);
      end else if (hfall && (hold_q != '0)) begin
         hold_d = hold_q - 1'b1;
      end

      if (field_start) begin
         // vsync falling in the second half of a line marks the odd field.
         field_int_d  = (x_cnt_q >= HALF_X);
         lines_last_d = y_cnt_q;
      end

      // Judge the field that just ended by the count being latched now.
      good_field = (lines_last_d >= LMIN_Y) && (lines_last_d <= LMAX_Y);
      if (timeout_d) begin
         good_d = 2'd0;
      end else if (field_start) begin
         if (!good_field) begin
            good_d = 2'd0;
         end else if (good_q != 2'd2) begin
            good_d = good_q + 2'd1;
         end
      end

      de_d = in_window(32'(x_cnt_q), H_START, H_ACTIVE) &
             in_window(32'(y_cnt_q), V_START, V_ACTIVE) &
             hsync & vsync & locked_int;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         prev_h_q     <= 1'b1;
         prev_v_q     <= 1'b1;
         x_cnt_q      <= '0;
         y_cnt_q      <= '0;
         hold_q       <= '0;
         field_int_q  <= 1'b0;
         lines_last_q <= '0;
         good_q       <= 2'd0;
         timeout_q    <= 1'b0;
         x_out_q      <= '0;
         y_out_q      <= '0;
         field_out_q  <= 1'b0;
         de_q         <= 1'b0;
      end else if (ce) begin
         prev_h_q     <= hsync;
         prev_v_q     <= vsync;
         x_cnt_q      <= x_cnt_d;
         y_cnt_q      <= y_cnt_d;
         hold_q       <= hold_d;
         field_int_q  <= field_int_d;
         lines_last_q <= lines_last_d;
         good_q       <= good_d;
         timeout_q    <= timeout_d;
         // Output copies share the one-ce latency of the luma register.
         x_out_q      <= x_cnt_q;
         y_out_q      <= y_cnt_q;
         field_out_q  <= field_int_q;
         de_q         <= de_d;
      end
   end

   luma_clamp #(
      .GAIN_SHL (GAIN_SHL)
   ) u_luma_clamp (
      .clk        (clk),
      .reset      (reset),
      .ce         (ce),
      .cvbs       (cvbs),
      .blacklevel (blacklevel),
      .blank      (porch | ~hsync),
      .luma       (luma)
   );

   assign de           = de_q;
   assign x            = x_out_q;
   assign y            = y_out_q;
   assign field        = field_out_q;
   assign locked       = locked_int;
   assign line_timeout = timeout_q;

endmodule

// File: tb/tb_video_timing_clamp.sv
// Directed bench for video_timing_clamp. Uses a shortened raster (64-sample
// lines, 22-line fields) so full field/lock sequences stay short.
module tb_video_timing_clamp;

   localparam int LL   = 64;   // samples per line
   localparam int HS_W = 4;    // hsync low width
   localparam int VS_W = 8;    // vsync low width
   localparam int H0   = 8;
   localparam int HA   = 40;
   localparam int V0   = 3;
   localparam int VA   = 10;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        ce = 1'b0;
   logic [5:0]  cvbs = '0;
   logic        hsync = 1'b1;
   logic        vsync = 1'b1;
   logic        porch = 1'b0;
   logic [5:0]  blacklevel = '0;
   logic [5:0]  luma_w;
   logic        de_w;
   logic [10:0] x_w;
   logic [8:0]  y_w;
   logic        field_w;
   logic        locked_w;
   logic        to_w;

   int n_checks = 0;
   int n_errors = 0;

   video_timing_clamp #(
      .H_START   (H0),
      .H_ACTIVE  (HA),
      .V_START   (V0),
      .V_ACTIVE  (VA),
      .HALFLINE  (32),
      .VS_HOLD   (4),
      .LINES_MIN (20),
      .LINES_MAX (23),
      .GAIN_SHL  (1)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .ce           (ce),
      .cvbs         (cvbs),
      .hsync        (hsync),
      .vsync        (vsync),
      .porch        (porch),
      .blacklevel   (blacklevel),
      .luma         (luma_w),
      .de           (de_w),
      .x            (x_w),
      .y            (y_w),
      .field        (field_w),
      .locked       (locked_w),
      .line_timeout (to_w)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One line; v_at >= 0 drops vsync at that sample, eq adds 10 vsync toggles
   // late in the line, yexp >= 0 checks the line number.
   task automatic run_line(input int v_at, input bit eq, input int yexp, input bit chk_de);
      int de_cnt;
      int de_first;
      int exp_cnt;
      de_cnt   = 0;
      de_first = -1;
      for (int i = 0; i < LL; i++) begin
         hsync = (i < HS_W) ? 1'b0 : 1'b1;
         if (v_at >= 0 && i >= v_at && i < v_at + VS_W) vsync = 1'b0;
         else if (eq && i >= 50 && i < 60) vsync = ((i - 50) % 2 == 0) ? 1'b0 : 1'b1;
         else vsync = 1'b1;
         step();
         if (i == 1) begin
            check("x_restart", 32'(x_w), 0);
            if (yexp >= 0) check($sformatf("y_line%0d", yexp), 32'(y_w), yexp);
         end
         if (i == LL - 1) check("x_line_end", 32'(x_w), LL - 2);
         if (chk_de) begin
            if (de_w === 1'b1) begin
               de_cnt++;
               if (de_first < 0) de_first = int'(x_w);
            end
            if (i == 2)  check("luma_hsync_blank", 32'(luma_w), 0);
            if (i == 30) check("luma_active", 32'(luma_w), 56);
         end
      end
      if (chk_de) begin
         exp_cnt = (yexp >= V0 && yexp < V0 + VA) ? HA : 0;
         check($sformatf("de_count_line%0d", yexp), de_cnt, exp_cnt);
         if (exp_cnt > 0) check($sformatf("de_first_x_line%0d", yexp), de_first, H0);
      end
   endtask

   task automatic run_field(input int n, input int v_at, input int exp_field,
                            input int exp_locked, input bit eq, input bit chk_de);
      run_line(v_at, 1'b0, (v_at == 0) ? 0 : -1, 1'b0);
      check("field", 32'(field_w), exp_field);
      check("locked", 32'(locked_w), exp_locked);
      for (int j = 1; j < n; j++) run_line(-1, eq && (j == 1), j, chk_de);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_luma"}, 32'(luma_w), 0);
      check({tag, "_de"}, 32'(de_w), 0);
      check({tag, "_x"}, 32'(x_w), 0);
      check({tag, "_y"}, 32'(y_w), 0);
      check({tag, "_field"}, 32'(field_w), 0);
      check({tag, "_locked"}, 32'(locked_w), 0);
      check({tag, "_timeout"}, 32'(to_w), 0);
   endtask

   // Clamp vectors: blacklevel, cvbs, porch, hsync, expected luma.
   int cv_bl [12] = '{12, 12, 12, 12, 12, 12,  0,  0, 12, 12, 12, 12};
   int cv_in [12] = '{10, 12, 20, 50, 44, 43, 31, 63, 13, 50, 50, 20};
   int cv_po [12] = '{ 0,  0,  0,  0,  0,  0,  0,  0,  0,  1,  0,  0};
   int cv_hs [12] = '{ 1,  1,  1,  1,  1,  1,  1,  1,  1,  1,  0,  1};
   int cv_ex [12] = '{ 0,  0, 16, 63, 63, 62, 62, 63,  2,  0,  0, 16};

   initial begin
      int pulses;
      int xs;

      // Reset applies even with ce low.
      reset = 1'b1;
      ce    = 1'b0;
      step();
      step();
      check_all_zero("reset");

      reset = 1'b0;
      ce    = 1'b1;
      for (int k = 0; k < 12; k++) begin
         blacklevel = 6'(cv_bl[k]);
         cvbs       = 6'(cv_in[k]);
         porch      = cv_po[k][0];
         hsync      = cv_hs[k][0];
         step();
         check($sformatf("clamp%0d", k), 32'(luma_w), cv_ex[k]);
      end
      check("de_unlocked", 32'(de_w), 0);

      // ce low holds every register.
      xs   = int'(x_w);
      ce   = 1'b0;
      cvbs = 6'd50;
      step();
      step();
      check("ce0_luma_hold", 32'(luma_w), 16);
      check("ce0_x_hold", 32'(x_w), xs);
      ce = 1'b1;

      // Field / lock sequence with cvbs 40, black 12 -> active luma 56.
      cvbs       = 6'd40;
      blacklevel = 6'd12;
      porch      = 1'b0;
      run_field(22, 11, 0, 0, 1'b0, 1'b0);   // A: first start, short count
      run_field(22,  0, 1, 0, 1'b0, 1'b0);   // B: vfall with hfall, 21 lines
      run_field(22, 11, 0, 1, 1'b0, 1'b0);   // C: second good field -> locked
      run_field(22, 43, 1, 1, 1'b1, 1'b1);   // D: de raster + equalising
      run_field(15, 11, 0, 1, 1'b0, 1'b0);   // E: 15-line field
      run_field(22, 43, 1, 0, 1'b0, 1'b0);   // F: bad count -> unlock
      run_field(22, 11, 0, 0, 1'b0, 1'b0);   // G
      run_field( 1, 43, 1, 1, 1'b0, 1'b0);   // H: relocked

      // hsync stuck high.
      hsync  = 1'b1;
      vsync  = 1'b1;
      pulses = 0;
      for (int i = 0; i < 3000; i++) begin
         step();
         if (to_w === 1'b1) pulses++;
      end
      check("timeout_pulses", pulses, 1);
      check("timeout_x_sat", 32'(x_w), 2047);
      check("timeout_locked", 32'(locked_w), 0);
      check("timeout_de", 32'(de_w), 0);
      check("timeout_idle", 32'(to_w), 0);

      // Let the vsync hold window expire, then relock.
      for (int j = 0; j < 5; j++) run_line(-1, 1'b0, -1, 1'b0);
      run_field(22, 11, 0, 0, 1'b0, 1'b0);   // I: bad count
      run_field(22, 11, 0, 0, 1'b0, 1'b0);   // J: good 1
      run_field( 3, 43, 1, 1, 1'b0, 1'b0);   // K: good 2 -> locked

      // Reset mid-line in an active line.
      for (int i = 0; i < LL; i++) begin
         hsync = (i < HS_W) ? 1'b0 : 1'b1;
         vsync = 1'b1;
         reset = (i == 21);
         step();
         if (i == 20) begin
            check("pre_reset_de", 32'(de_w), 1);
            check("pre_reset_luma", 32'(luma_w), 56);
            check("pre_reset_x", 32'(x_w), 19);
            check("pre_reset_y", 32'(y_w), 3);
         end
         if (i == 21) check_all_zero("midline_reset");
      end
      reset = 1'b0;
      run_line(-1, 1'b0, 1, 1'b0);
      check("post_reset_locked", 32'(locked_w), 0);
      check("post_reset_field", 32'(field_w), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
